myproject_mul_pipe_sat: RTL
===========================

Name: myproject_mul_pipe_sat

Overview:
Parametrised, pipelined signed multiplier for the layer datapaths (MHA projections, dense).
Computes a full-precision product, then optionally arithmetic-shifts it right (truncate or round), then narrows it to the output width (wrap or saturate).
Uses a valid/ready handshake with a global pipeline stall, so it can sit between buffered stages that apply backpressure.
Raises a per-result overflow flag and a sticky overflow flag for debug.

Parameters:
DIN0_WIDTH, 16, signed operand 0 width (2..32)
DIN1_WIDTH, 16, signed operand 1 width (2..32)
DOUT_WIDTH, 26, result width (2..DIN0_WIDTH+DIN1_WIDTH)
NUM_STAGE, 2, pipeline latency in accepted cycles (1..6)
SHIFT, 0, arithmetic right shift applied to the product (0..DIN0_WIDTH+DIN1_WIDTH-2)
ROUND_MODE, 0, 0 = truncate toward -inf, 1 = round half up (ignored when SHIFT=0)
SAT_MODE, 1, 0 = wrap (keep LSBs), 1 = saturate to DOUT range

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous, active-low reset
din_valid  in  1  operands valid
din_ready  out  1  block can accept operands
din0  in  DIN0_WIDTH  signed operand 0
din1  in  DIN1_WIDTH  signed operand 1
dout_valid  out  1  result valid
dout_ready  in  1  downstream accepts result
dout  out  DOUT_WIDTH  signed result
dout_ovf  out  1  narrowing changed the value of this result
ovf_sticky  out  1  OR of dout_ovf over all results since reset/clear
ovf_clr  in  1  synchronous clear of ovf_sticky

Behaviour:
- Reset: one clock; ap_rst_n is asynchronous and active-low.
  - Every stage valid bit, dout, dout_ovf and ovf_sticky clear to 0 immediately when ap_rst_n asserts.
  - Data registers also clear to 0.
  - Reset mid-operation discards all in-flight results; no partial output is produced.
- Arithmetic, with P = DIN0_WIDTH+DIN1_WIDTH:
  - prod = signed(din0)*signed(din1), P bits, exact.
  - If ROUND_MODE=1 and SHIFT>0: s = (prod + 2^(SHIFT-1)) >>> SHIFT, with the add done in P+1 bits.
  - Otherwise: s = prod >>> SHIFT.
  - SAT_MODE=1: dout = clamp(s, -2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1).
  - SAT_MODE=0: dout = s[DOUT_WIDTH-1:0].
  - dout_ovf=1 iff s lies outside the DOUT range, in either mode.
- Pipeline:
  - NUM_STAGE register stages, each holding a valid bit, data and ovf.
  - advance = !dout_valid || dout_ready. Every stage shifts only when advance=1.
  - Bubbles are not collapsed (simple global stall).
  - din_ready = advance, combinational from dout_valid and dout_ready.
  - Operands are accepted when din_valid && din_ready.
  - Latency: a result appears on dout exactly NUM_STAGE advancing cycles after acceptance. With dout_ready held at 1 this is NUM_STAGE clocks.
  - Throughput: 1 result per clock when unstalled.
- Stall:
  - While dout_valid && !dout_ready, dout, dout_valid and dout_ovf hold stable. No result is lost or duplicated.
- Arithmetic placement:
  - Stage 1 registers the operands.
  - The multiply, shift/round and narrowing sit between stage 1 and stage 2.
  - Any further stages only delay the result, and may be retimed by synthesis.
  - NUM_STAGE=1 puts the full combinational path before the single register.
- ovf_sticky:
  - Set on the cycle a result with dout_ovf=1 is transferred (dout_valid && dout_ready).
  - ovf_clr=1 clears it.
  - Simultaneous set and clear: set wins.
- Extremes:
  - -2^(DIN0_WIDTH-1) * -2^(DIN1_WIDTH-1) must not wrap internally; the P-bit product is exact.
  - A rounding carry beyond the maximum value is handled by the P+1-bit add.
- X on din0/din1 while din_valid=0 must not propagate to the control signals.

Decomposition:
- Package myproject_mul_pkg holds:
  - constants ROUND_TRUNC=0, ROUND_HALF_UP=1, SAT_WRAP=0, SAT_CLAMP=1;
  - function prod_width(a,b);
  - elaboration-time parameter range checks.
- Sub-module myproject_mul_narrow: purely combinational shift/round/saturate from P bits to DOUT_WIDTH bits, with an ovf output. It is reusable by the accumulator blocks.
- The top level owns the multiply, the handshake and the pipeline registers.

Test Plan:
- Defaults (SAT_MODE=1), dout_ready=1: 0x7FFF*0x7FFF → after 2 clk dout=26'h1FFFFFF, dout_ovf=1, ovf_sticky=1. Then -3*5 → 26'h3FFFFF1, dout_ovf=0.
- SAT_MODE=0: 0x7FFF*0x7FFF → dout=26'h3FF0001, dout_ovf=1. Also 0x8000*0x8000 → dout=26'h0000000, dout_ovf=1 (SAT_MODE=1 gives 26'h1FFFFFF).
- SHIFT=4, DOUT_WIDTH=16:
  - 3*8: ROUND_MODE=0 gives 1, ROUND_MODE=1 gives 2.
  - -3*8: ROUND_MODE=0 gives -2 (16'hFFFE), ROUND_MODE=1 gives -1 (16'hFFFF).
- Backpressure: stream 8 back-to-back operands with dout_ready toggling randomly → all 8 results in order, dout stable while stalled, din_ready=0 exactly when dout_valid && !dout_ready.
- Reset: deassert ap_rst_n asynchronously (between clock edges) with 2 results in flight → dout_valid, dout, ovf_sticky go to 0 immediately, and no stale result appears after release.
- Sticky flag: ovf_clr asserted in the same cycle an overflowing result transfers → ovf_sticky=1. ovf_clr alone on the next cycle → 0. Sweep NUM_STAGE=1..6 and confirm latency equals NUM_STAGE clocks.

Source files
------------

// File: rtl/myproject_mul_pkg.sv
// Shared constants and helpers for the pipelined multiplier and narrowing logic.
package myproject_mul_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;
  localparam int SAT_WRAP      = 0;
  localparam int SAT_CLAMP     = 1;

  // Width of an exact signed product of two operands.
  function automatic int prod_width(input int a, input int b);
    return a + b;
  endfunction

  // Legal parameter ranges for myproject_mul_pipe_sat.
  function automatic bit params_ok(input int din0W, input int din1W, input int doutW,
                                   input int numStage, input int shift,
                                   input int roundMode, input int satMode);
    bit ok;
    ok = 1'b1;
    if (din0W < 2 || din0W > 32) ok = 1'b0;
    if (din1W < 2 || din1W > 32) ok = 1'b0;
    if (doutW < 2 || doutW > prod_width(din0W, din1W)) ok = 1'b0;
    if (numStage < 1 || numStage > 6) ok = 1'b0;
    if (shift < 0 || shift > prod_width(din0W, din1W) - 2) ok = 1'b0;
    if (roundMode != ROUND_TRUNC && roundMode != ROUND_HALF_UP) ok = 1'b0;
    if (satMode != SAT_WRAP && satMode != SAT_CLAMP) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/myproject_mul_narrow.sv
// Combinational shift / round / narrow of a signed product down to the result width.
// Shared with the accumulator blocks, so it knows nothing about handshakes.
module myproject_mul_narrow
  import myproject_mul_pkg::*;
#(
  parameter int PROD_WIDTH = 32,
  parameter int DOUT_WIDTH = 26,
  parameter int SHIFT      = 0,
  parameter int ROUND_MODE = ROUND_TRUNC,
  parameter int SAT_MODE   = SAT_CLAMP
) (
  input  logic signed [PROD_WIDTH-1:0] prod_i,
  output logic signed [DOUT_WIDTH-1:0] dout_o,
  output logic                         ovf_o
);

  // One extra bit keeps a rounding carry out of the top of the product.
  localparam int EXT_WIDTH = PROD_WIDTH + 1;
  localparam int BIAS_POS  = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [EXT_WIDTH-1:0] BIAS =
    (ROUND_MODE == ROUND_HALF_UP && SHIFT > 0) ? (EXT_WIDTH'(1) << BIAS_POS) : '0;
  localparam logic [DOUT_WIDTH-1:0] MAX_VAL = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DOUT_WIDTH-1:0] MIN_VAL = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  logic signed [EXT_WIDTH-1:0]        extProd;
  logic signed [EXT_WIDTH-1:0]        biased;
  logic signed [EXT_WIDTH-1:0]        shifted;
  logic        [EXT_WIDTH-DOUT_WIDTH:0] upper;
  logic                               outOfRange;

  // Out of range whenever the bits above the result sign bit are not a pure sign extension.
  always_comb begin
    extProd    = {prod_i[PROD_WIDTH-1], prod_i};
    biased     = extProd + $signed(BIAS);
    shifted    = biased >>> SHIFT;
    upper      = shifted[EXT_WIDTH-1:DOUT_WIDTH-1];
    outOfRange = !((&upper) || !(|upper));
    ovf_o      = outOfRange;
    if (outOfRange && SAT_MODE == SAT_CLAMP) begin
      dout_o = shifted[EXT_WIDTH-1] ? MIN_VAL : MAX_VAL;
    end else begin
      dout_o = shifted[DOUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/myproject_mul_pipe_sat.sv
// Pipelined signed multiplier with shift/round, wrap/saturate narrowing,
// a globally stalled valid/ready pipeline and per-result / sticky overflow flags.
module myproject_mul_pipe_sat
  import myproject_mul_pkg::*;
#(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 16,
  parameter int DOUT_WIDTH = 26,
  parameter int NUM_STAGE  = 2,
  parameter int SHIFT      = 0,
  parameter int ROUND_MODE = ROUND_TRUNC,
  parameter int SAT_MODE   = SAT_CLAMP
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         dout_ovf,
  output logic                         ovf_sticky,
  input  logic                         ovf_clr
);

  localparam int P          = prod_width(DIN0_WIDTH, DIN1_WIDTH);
  localparam int RES_STAGES = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;

  if (!params_ok(DIN0_WIDTH, DIN1_WIDTH, DOUT_WIDTH, NUM_STAGE, SHIFT, ROUND_MODE, SAT_MODE)) begin : g_bad_params
    $error("myproject_mul_pipe_sat: parameter out of range");
  end

  logic                         advance;
  logic signed [DIN0_WIDTH-1:0] mulA;
  logic signed [DIN1_WIDTH-1:0] mulB;
  logic                         mulValid;
  logic signed [P-1:0]          prod;
  logic signed [DOUT_WIDTH-1:0] resData_d;
  logic                         resOvf_d;

  logic                         resValid_q [RES_STAGES];
  logic signed [DOUT_WIDTH-1:0] resData_q  [RES_STAGES];
  logic                         resOvf_q   [RES_STAGES];
  logic                         ovfSticky_q;

  assign advance   = !dout_valid || dout_ready;
  assign din_ready = advance;

  if (NUM_STAGE == 1) begin : g_no_opreg
    assign mulA     = din0;
    assign mulB     = din1;
    assign mulValid = din_valid;
  end else begin : g_opreg
    logic                         opValid_q;
    logic signed [DIN0_WIDTH-1:0] op0_q;
    logic signed [DIN1_WIDTH-1:0] op1_q;

    // Operand register; data only loads on a real acceptance so idle X never enters.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        opValid_q <= 1'b0;
        op0_q     <= '0;
        op1_q     <= '0;
      end else if (advance) begin
        opValid_q <= din_valid;
        if (din_valid) begin
          op0_q <= din0;
          op1_q <= din1;
        end
      end
    end

    assign mulA     = op0_q;
    assign mulB     = op1_q;
    assign mulValid = opValid_q;
  end

  // Operands are widened to P bits first, so the most negative squared never wraps.
  assign prod = P'(mulA) * P'(mulB);

  myproject_mul_narrow #(
    .PROD_WIDTH (P),
    .DOUT_WIDTH (DOUT_WIDTH),
    .SHIFT      (SHIFT),
    .ROUND_MODE (ROUND_MODE),
    .SAT_MODE   (SAT_MODE)
  ) u_narrow (
    .prod_i (prod),
    .dout_o (resData_d),
    .ovf_o  (resOvf_d)
  );

  // Result delay line; the whole chain shifts together, bubbles are kept in place.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < RES_STAGES; i++) begin
        resValid_q[i] <= 1'b0;
        resData_q[i]  <= '0;
        resOvf_q[i]   <= 1'b0;
      end
    end else if (advance) begin
      resValid_q[0] <= mulValid;
      if (mulValid) begin
        resData_q[0] <= resData_d;
        resOvf_q[0]  <= resOvf_d;
      end
      for (int i = 1; i < RES_STAGES; i++) begin
        resValid_q[i] <= resValid_q[i-1];
        if (resValid_q[i-1]) begin
          resData_q[i] <= resData_q[i-1];
          resOvf_q[i]  <= resOvf_q[i-1];
        end
      end
    end
  end

  assign dout_valid = resValid_q[RES_STAGES-1];
  assign dout       = resData_q[RES_STAGES-1];
  assign dout_ovf   = resOvf_q[RES_STAGES-1];

  // Sticky overflow: a transferring overflow result beats a simultaneous clear.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ovfSticky_q <= 1'b0;
    end else if (dout_valid && dout_ready && dout_ovf) begin
      ovfSticky_q <= 1'b1;
    end else if (ovf_clr) begin
      ovfSticky_q <= 1'b0;
    end
  end

  assign ovf_sticky = ovfSticky_q;

endmodule
